dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Single-outstanding data-memory responder for an RV32I core. A request is
// accepted in IDLE. Stores are committed to the internal word array on the
// accepting edge. Loads read the array on that same edge and register the
// extended result. After LATENCY cycles the response is presented, and it
// is held until the core takes it.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous active-high reset
//   req_valid    core presents a load/store request
//   req_ready    high only in IDLE; acceptance is req_valid && req_ready
//   req_write    1 = store, 0 = load
//   req_size     RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   resp_valid   response available (RESP state)
//   resp_ready   core accepts the response
//   resp_rdata   extended load data; 0 for stores and errors
//   resp_err     misaligned, illegal size, or out-of-range request

module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      stateQ, stateD;
   logic [3:0]  cntQ, cntD;
   logic [31:0] rdataQ, rdataD;
   logic        errQ, errD;

   logic [31:0] mem [DEPTH_WORDS];

   logic          accept;
   logic          sizeErr, alignErr, rangeErr, reqErr;
   logic [AW-1:0] wordIdx;
   logic [31:0]   rdWord, shifted, loadVal;
   logic [3:0]    byteEn;
   logic [31:0]   wrData;

   assign accept  = req_valid && req_ready && !reset;
   assign wordIdx = req_addr[AW+1:2];
   assign rdWord  = mem[wordIdx];

   // Classify the request. BU/HU are load-only encodings, so they are
   // illegal for stores. The range test uses the whole word index, so
   // high address bits above the array are caught as well.
   always_comb begin
      sizeErr  = 1'b0;
      alignErr = 1'b0;
      case (req_size)
         3'b000:         sizeErr = 1'b0;
         3'b001:         alignErr = req_addr[0];
         3'b010:         alignErr = (req_addr[1:0] != 2'b00);
         3'b100:         sizeErr = req_write;
         3'b101: begin
            sizeErr  = req_write;
            alignErr = req_addr[0];
         end
         default:        sizeErr = 1'b1;
      endcase
      rangeErr = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
      reqErr   = sizeErr || alignErr || rangeErr;
   end

   // Bring the addressed byte/half down to bit 0, then sign- or zero-extend
   // it according to the load flavour.
   always_comb begin
      shifted = rdWord >> {req_addr[1:0], 3'b000};
      case (req_size)
         3'b000:  loadVal = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  loadVal = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  loadVal = {24'd0, shifted[7:0]};
         3'b101:  loadVal = {16'd0, shifted[15:0]};
         default: loadVal = rdWord;
      endcase
   end

   // Store lane selection. The store data is replicated across all lanes,
   // so each enabled lane simply picks up its own slice.
   always_comb begin
      case (req_size)
         3'b000: begin
            byteEn = 4'b0001 << req_addr[1:0];
            wrData = {4{req_wdata[7:0]}};
         end
         3'b001: begin
            byteEn = req_addr[1] ? 4'b1100 : 4'b0011;
            wrData = {2{req_wdata[15:0]}};
         end
         default: begin
            byteEn = 4'b1111;
            wrData = req_wdata;
         end
      endcase
   end

   // The array has no reset, so its contents survive reset. Only legal
   // stores write it, and only on the accepting edge.
   always_ff @(posedge clk) begin
      if (accept && req_write && !reqErr) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) begin
               mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
         end
      end
   end

   // State register, latency counter and the captured response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ <= IDLE;
         cntQ   <= 4'd0;
         rdataQ <= 32'd0;
         errQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         rdataQ <= rdataD;
         errQ   <= errD;
      end
   end

   // Next-state logic. The counter is loaded with LATENCY-1 so that the
   // response appears LATENCY edges after acceptance. The response payload
   // is captured only at acceptance, so it stays stable through RESP.
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      rdataD = rdataQ;
      errD   = errQ;
      case (stateQ)
         IDLE: begin
            if (accept) begin
               errD   = reqErr;
               rdataD = (req_write || reqErr) ? 32'd0 : loadVal;
               if (LATENCY == 1) begin
                  stateD = RESP;
                  cntD   = 4'd0;
               end else begin
                  stateD = WAIT;
                  cntD   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cntQ <= 4'd1) begin
               stateD = RESP;
               cntD   = 4'd0;
            end else begin
               cntD = cntQ - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // Outputs are decoded from the state alone. A new request is never
   // accepted in the same cycle that the response handshake completes.
   always_comb begin
      req_ready  = (stateQ == IDLE);
      resp_valid = (stateQ == RESP);
      resp_rdata = rdataQ;
      resp_err   = errQ;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Table-driven bench for dmem_responder. The expected response for each
// request is queued when the request is driven and is popped when the
// response appears. The multi-cycle corner cases (response back-pressure
// and reset mid-flight) are written out as hand sequences.

module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;
   localparam int BOUND = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[19];
   int   nChecks = 0;
   int   nFails  = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Report an expired wait bound as a failed comparison.
   task automatic timeoutFail(input string name);
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: timed out after %0d cycles", name, BOUND);
   endtask

   // Drive a request on a falling edge and queue its expected response.
   task automatic driveReq(input vec_t v);
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = v.wr;
      req_size  = v.size;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      e.data    = v.expData;
      e.err     = v.expErr;
      sb.push_back(e);
   endtask

   // Wait for the accepting edge, then scramble the request fields. Any
   // sampling outside the accepting edge would then corrupt the result.
   task automatic waitAccept(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < BOUND; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         timeoutFail({name, " accept"});
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_size  = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   // Drive a request and wait for it to be accepted.
   task automatic applyStimulus(input vec_t v, input string name, output bit ok);
      driveReq(v);
      waitAccept(name, ok);
   endtask

   // Count falling edges after acceptance until resp_valid is seen.
   // Checks the latency, the payload against the scoreboard, and
   // req_ready low. When doHandshake is set, the response is also taken.
   task automatic collectResponse(input string name, input bit doHandshake);
      int   k;
      bit   seen;
      exp_t e;
      seen = 1'b0;
      k    = 0;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clk);
         k++;
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (sb.size() == 0) begin
         timeoutFail({name, " scoreboard empty"});
         return;
      end
      e = sb.pop_front();
      if (!seen) begin
         timeoutFail({name, " resp_valid"});
         return;
      end
      checkOutput({name, " latency"}, 32'(k), 32'(LAT));
      checkOutput({name, " rdata"}, resp_rdata, e.data);
      checkOutput({name, " err"}, 32'(resp_err), 32'(e.err));
      checkOutput({name, " req_ready in RESP"}, 32'(req_ready), 32'd0);
      if (doHandshake) begin
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
      end
   endtask

   // One complete request/response transaction.
   task automatic transact(input vec_t v, input string name);
      bit ok;
      applyStimulus(v, name, ok);
      if (ok) begin
         collectResponse(name, 1'b1);
      end else begin
         void'(sb.pop_back());
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData, input logic expErr);
      vec_t v;
      v.wr      = wr;
      v.size    = size;
      v.addr    = addr;
      v.wdata   = wdata;
      v.expData = expData;
      v.expErr  = expErr;
      return v;
   endfunction

   initial begin
      vec_t v;
      bit   ok;
      logic [31:0] heldData;

      vecs[0]  = mk(1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
      vecs[1]  = mk(1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      vecs[2]  = mk(1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0);
      vecs[3]  = mk(1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0);
      vecs[4]  = mk(1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0);
      vecs[5]  = mk(1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0);
      vecs[6]  = mk(1'b1, 3'b000, 32'h11,  32'h55,       32'h0,        1'b0);
      vecs[7]  = mk(1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0);
      vecs[8]  = mk(1'b1, 3'b001, 32'h12,  32'h1234,     32'h0,        1'b0);
      vecs[9]  = mk(1'b0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0);
      vecs[10] = mk(1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1);
      vecs[11] = mk(1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1);
      vecs[12] = mk(1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1);
      vecs[13] = mk(1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0,        1'b1);
      vecs[14] = mk(1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1);
      vecs[15] = mk(1'b0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0);
      vecs[16] = mk(1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0);
      vecs[17] = mk(1'b0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0);
      vecs[18] = mk(1'b0, 3'b000, 32'h11,  32'h0,        32'h00000055, 1'b0);

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset resp_err", 32'(resp_err), 32'd0);
      checkOutput("reset resp_rdata", resp_rdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);

      // Main vector table.
      foreach (vecs[i]) begin
         transact(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-pressure: hold resp_ready low for five cycles while the next
      // request waits on req_valid.
      v = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
      applyStimulus(v, "hold", ok);
      if (ok) begin
         collectResponse("hold", 1'b0);
         heldData = resp_rdata;
         v = mk(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000012, 1'b0);
         driveReq(v);
         for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("hold c%0d resp_valid", i), 32'(resp_valid), 32'd1);
            checkOutput($sformatf("hold c%0d rdata", i), resp_rdata, heldData);
            checkOutput($sformatf("hold c%0d req_ready", i), 32'(req_ready), 32'd0);
         end
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
         @(negedge clk);
         checkOutput("hold post-handshake resp_valid", 32'(resp_valid), 32'd0);
         checkOutput("hold second not yet accepted", 32'(req_ready), 32'd1);
         waitAccept("hold2", ok);
         if (ok) collectResponse("hold2", 1'b1);
         else void'(sb.pop_back());
      end else begin
         void'(sb.pop_back());
      end

      // Reset while a load waits: the response must be discarded.
      transact(mk(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0), "rst store");
      applyStimulus(mk(1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0), "rst load", ok);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      checkOutput("rst during resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rst after c%0d resp_valid", i), 32'(resp_valid), 32'd0);
         checkOutput($sformatf("rst after c%0d req_ready", i), 32'(req_ready), 32'd1);
      end
      transact(mk(1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0), "rst reload");

      // A store interrupted by reset must still be written.
      applyStimulus(mk(1'b1, 3'b010, 32'h24, 32'h0BADF00D, 32'h0, 1'b0), "rst store2", ok);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst store2 resp_valid", 32'(resp_valid), 32'd0);
      transact(mk(1'b0, 3'b010, 32'h24, 32'h0, 32'h0BADF00D, 1'b0), "rst store2 readback");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
